// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between two requesters:
//   port A - CPU MEM stage (high priority)
//   port B - DMA / debug loader (low priority, starvation-protected)
//
// A winning request is latched in IDLE and drives the memory for one SERVE
// cycle. A one-cycle ack follows in ACK. One access therefore takes three
// cycles: request seen at N, memory access at N+1, ack at N+2.
//
// Parameters:
//   MAX_WAIT - cycles B may wait while A keeps winning before B is forced
//              ahead (1..15)
//   AW       - address width of both requester ports and the memory address
//
// Ports:
//   clk, rst_n                 - clock (rising edge), async active-low reset
//   a_req/a_we/a_addr/a_wdata  - port A request, write flag, address, data
//   a_ack/a_rdata              - port A completion pulse and read data
//   b_*                        - same as port A, for port B
//   mem_ce/mem_we              - memory chip enable / write enable
//   mem_addr/mem_wdata         - memory address / write data
//   mem_rdata                  - memory read data (combinational from addr)
//   err                        - address-fault pulse, valid with the ack
//
// Optional feature macro: DMEM_ARB_ADDR_CHECK_EN
//   When defined, a granted address with nonzero bits above bit 11 or a
//   nonzero byte offset is faulted: no memory access, rdata loads 0, and err
//   pulses together with the ack. When undefined, err is tied to 0 and all
//   addresses pass through (the memory aliases on addr[11:2]).
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic          a_ack,
  output logic [31:0]   a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic          b_ack,
  output logic [31:0]   b_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t          state;
  state_t          next_state;
  logic            owner_b;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      wait_cnt;
  logic            b_wins;
  logic            a_wins;
  logic            fault;

  // B wins when it is alone, or when it has waited long enough that A's
  // priority is overridden; otherwise any A request wins.
  always_comb begin
    b_wins = b_req && (!a_req || (wait_cnt >= MAX_WAIT_C));
    a_wins = a_req && !b_wins;
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  // Only the 4 KB window (word-aligned) is legal; everything else faults.
  always_comb begin
    fault = (lat_addr[AW-1:12] != '0) || (lat_addr[1:0] != 2'b00);
  end
`else
  always_comb begin
    fault = 1'b0;
  end
`endif

  // State register. Reset drops straight back to IDLE so an in-flight
  // access never reaches its ack and mem_ce falls without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and memory/ack strobes. Arbitration happens only in IDLE;
  // ACK always returns to IDLE so a held request is re-arbitrated fresh.
  always_comb begin
    next_state = state;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (a_wins) begin
          next_state = SERVE_A;
        end else if (b_wins) begin
          next_state = SERVE_B;
        end
      end
      SERVE_A, SERVE_B: begin
        mem_ce     = !fault;
        mem_we     = lat_we && !fault;
        next_state = ACK;
      end
      ACK: begin
        a_ack      = !owner_b;
        b_ack      = owner_b;
        err        = fault;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch: captured at grant and held afterwards, which is also why
  // mem_addr/mem_wdata keep their last values outside SERVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_b   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE) begin
      if (a_wins) begin
        owner_b   <= 1'b0;
        lat_we    <= a_we;
        lat_addr  <= a_addr;
        lat_wdata <= a_wdata;
      end else if (b_wins) begin
        owner_b   <= 1'b1;
        lat_we    <= b_we;
        lat_addr  <= b_addr;
        lat_wdata <= b_wdata;
      end
    end
  end

  always_comb begin
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
  end

  // Starvation counter: counts every cycle B is asking but not being
  // served, saturating at 15; a B grant resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if ((state == IDLE) && b_wins) begin
      wait_cnt <= 4'd0;
    end else if (b_req && (state != SERVE_B) && (wait_cnt != 4'd15)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Read data capture at the edge ending SERVE. Writes leave rdata alone;
  // a faulted access returns 0 instead of memory contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
    end else begin
      if (state == SERVE_A) begin
        if (fault) begin
          a_rdata <= 32'd0;
        end else if (!lat_we) begin
          a_rdata <= mem_rdata;
        end
      end
      if (state == SERVE_B) begin
        if (fault) begin
          b_rdata <= 32'd0;
        end else if (!lat_we) begin
          b_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
